// File: rtl/bure_alu_arb_pkg.sv
// Shared types and constants for the bure_alu_arb slice.
// The optional grant counters are enabled by the macro BURE_ALU_ARB_PERF_EN.
package bure_alu_arb_pkg;

   localparam int ARB_PORTS    = 2;
   localparam int PKG_DATA_W   = 32;
   localparam int PKG_TAG_W    = 5;

   // RISC-V style ALU operation selector (funct3 field)
   typedef enum logic [2:0] {
      F3_ADD  = 3'd0,
      F3_SLL  = 3'd1,
      F3_SLT  = 3'd2,
      F3_SLTU = 3'd3,
      F3_XOR  = 3'd4,
      F3_SR   = 3'd5,
      F3_OR   = 3'd6,
      F3_AND  = 3'd7
   } alu_f3_e;

   // One ALU request as presented by a requester (default widths)
   typedef struct packed {
      logic                  force_add;
      logic [2:0]            funct3;
      logic [6:0]            funct7;
      logic [PKG_DATA_W-1:0] lhs;
      logic [PKG_DATA_W-1:0] rhs;
      logic [PKG_TAG_W-1:0]  tag;
   } alu_req_t;

endpackage

// File: rtl/bure_alu.sv
// Combinational integer ALU (RV32I register/immediate ops).
// funct7[5] selects SUB for ADD and SRA for the right shift; force_add overrides to ADD.
module bure_alu
   import bure_alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_force_add,
   input  logic [2:0]            i_funct3,
   input  logic [6:0]            i_funct7,
   input  logic [DATA_WIDTH-1:0] i_lhs,
   input  logic [DATA_WIDTH-1:0] i_rhs,
   output logic [DATA_WIDTH-1:0] o_result
);

   localparam int SHW = $clog2(DATA_WIDTH);

   logic [SHW-1:0] w_shamt;
   logic           w_alt;
   logic [6+DATA_WIDTH-SHW-1:0] w_unused_bits;

   assign w_shamt       = i_rhs[SHW-1:0];
   assign w_alt         = i_funct7[5];
   assign w_unused_bits = {i_funct7[6], i_funct7[4:0], i_rhs[DATA_WIDTH-1:SHW]};

   // Operation select and evaluation
   always_comb begin
      o_result = '0;
      if (i_force_add) begin
         o_result = i_lhs + i_rhs;
      end else begin
         case (alu_f3_e'(i_funct3))
            F3_ADD:  o_result = w_alt ? (i_lhs - i_rhs) : (i_lhs + i_rhs);
            F3_SLL:  o_result = i_lhs << w_shamt;
            F3_SLT:  o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_lhs) < $signed(i_rhs))};
            F3_SLTU: o_result = {{(DATA_WIDTH-1){1'b0}}, (i_lhs < i_rhs)};
            F3_XOR:  o_result = i_lhs ^ i_rhs;
            F3_SR:   o_result = w_alt ? DATA_WIDTH'($signed(i_lhs) >>> w_shamt)
                                      : (i_lhs >> w_shamt);
            F3_OR:   o_result = i_lhs | i_rhs;
            F3_AND:  o_result = i_lhs & i_rhs;
            default: o_result = '0;
         endcase
      end
   end

endmodule

// File: rtl/bure_alu_arb_rr.sv
// bure_rr_arb2: two-way round-robin grant with a last-grant pointer.
// The pointer moves only when the caller signals that the grant was taken.
module bure_rr_arb2
   import bure_alu_arb_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [ARB_PORTS-1:0] i_req,
   input  logic                 i_advance,
   output logic [ARB_PORTS-1:0] o_gnt
);

   logic r_last;

   // Grant: a lone requester wins, on contention the port other than r_last wins
   always_comb begin
      o_gnt = '0;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
         default: o_gnt = '0;
      endcase
   end

   // Last-grant pointer; resets to 1 so port 0 wins the first contention
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (i_advance) begin
         r_last <= o_gnt[1];
      end
   end

endmodule

// File: rtl/bure_alu_arb.sv
// bure_alu_arb: shares one bure_alu between two requesters with round-robin
// arbitration and a single registered response stage.
// Optional grant counters are built when BURE_ALU_ARB_PERF_EN is defined.
module bure_alu_arb
   import bure_alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req0_valid,
   output logic                  o_req0_ready,
   input  logic                  i_req0_force_add,
   input  logic [2:0]            i_req0_funct3,
   input  logic [6:0]            i_req0_funct7,
   input  logic [DATA_WIDTH-1:0] i_req0_lhs,
   input  logic [DATA_WIDTH-1:0] i_req0_rhs,
   input  logic [TAG_WIDTH-1:0]  i_req0_tag,
   input  logic                  i_req1_valid,
   output logic                  o_req1_ready,
   input  logic                  i_req1_force_add,
   input  logic [2:0]            i_req1_funct3,
   input  logic [6:0]            i_req1_funct7,
   input  logic [DATA_WIDTH-1:0] i_req1_lhs,
   input  logic [DATA_WIDTH-1:0] i_req1_rhs,
   input  logic [TAG_WIDTH-1:0]  i_req1_tag,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic                  o_rsp_id,
   output logic [TAG_WIDTH-1:0]  o_rsp_tag,
   output logic [CNT_WIDTH-1:0]  o_gnt_cnt0,
   output logic [CNT_WIDTH-1:0]  o_gnt_cnt1
);

   logic [ARB_PORTS-1:0]  w_req;
   logic [ARB_PORTS-1:0]  w_gnt;
   logic                  w_stage_free;
   logic                  w_accept;
   logic                  w_sel;
   logic                  w_force_add;
   logic [2:0]            w_funct3;
   logic [6:0]            w_funct7;
   logic [DATA_WIDTH-1:0] w_lhs;
   logic [DATA_WIDTH-1:0] w_rhs;
   logic [TAG_WIDTH-1:0]  w_tag;
   logic [DATA_WIDTH-1:0] w_result;

   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_id;
   logic [TAG_WIDTH-1:0]  r_rsp_tag;

   assign w_req        = {i_req1_valid, i_req0_valid};
   assign w_stage_free = !r_rsp_valid || i_rsp_ready;
   // Readies are suppressed during reset so nothing is accepted into a stage being cleared
   assign o_req0_ready = w_stage_free && w_gnt[0] && !i_rst;
   assign o_req1_ready = w_stage_free && w_gnt[1] && !i_rst;
   // A grant is only ever issued to a valid port, so ready alone implies accept
   assign w_accept     = o_req0_ready || o_req1_ready;
   assign w_sel        = w_gnt[1];

   bure_rr_arb2 u_arb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (w_req),
      .i_advance (w_accept),
      .o_gnt     (w_gnt)
   );

   // Operand mux driven from the granted port (port 0 when nothing is granted)
   always_comb begin
      w_force_add = i_req0_force_add;
      w_funct3    = i_req0_funct3;
      w_funct7    = i_req0_funct7;
      w_lhs       = i_req0_lhs;
      w_rhs       = i_req0_rhs;
      w_tag       = i_req0_tag;
      if (w_sel) begin
         w_force_add = i_req1_force_add;
         w_funct3    = i_req1_funct3;
         w_funct7    = i_req1_funct7;
         w_lhs       = i_req1_lhs;
         w_rhs       = i_req1_rhs;
         w_tag       = i_req1_tag;
      end
   end

   bure_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .i_force_add (w_force_add),
      .i_funct3    (w_funct3),
      .i_funct7    (w_funct7),
      .i_lhs       (w_lhs),
      .i_rhs       (w_rhs),
      .o_result    (w_result)
   );

   // Response stage: load on accept, drain when consumed, hold under backpressure
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= 1'b0;
         r_rsp_tag   <= '0;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= w_result;
         r_rsp_id    <= w_sel;
         r_rsp_tag   <= w_tag;
      end else if (i_rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_tag   = r_rsp_tag;

`ifdef BURE_ALU_ARB_PERF_EN
   logic [CNT_WIDTH-1:0] r_gnt_cnt0;
   logic [CNT_WIDTH-1:0] r_gnt_cnt1;

   // Saturating per-port accept counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gnt_cnt0 <= '0;
         r_gnt_cnt1 <= '0;
      end else begin
         if (o_req0_ready && (r_gnt_cnt0 != '1)) begin
            r_gnt_cnt0 <= r_gnt_cnt0 + CNT_WIDTH'(1);
         end
         if (o_req1_ready && (r_gnt_cnt1 != '1)) begin
            r_gnt_cnt1 <= r_gnt_cnt1 + CNT_WIDTH'(1);
         end
      end
   end

   assign o_gnt_cnt0 = r_gnt_cnt0;
   assign o_gnt_cnt1 = r_gnt_cnt1;
`else
   assign o_gnt_cnt0 = '0;
   assign o_gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_bure_alu_arb.sv
// Randomized + directed bench for bure_alu_arb against a transaction-level model.
// Counter expectations follow BURE_ALU_ARB_PERF_EN; a second instance uses CNT_WIDTH=2.
module tb_bure_alu_arb;
   import bure_alu_arb_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req0_valid, i_req1_valid;
   logic        o_req0_ready, o_req1_ready;
   logic        i_req0_force_add, i_req1_force_add;
   logic [2:0]  i_req0_funct3, i_req1_funct3;
   logic [6:0]  i_req0_funct7, i_req1_funct7;
   logic [31:0] i_req0_lhs, i_req0_rhs, i_req1_lhs, i_req1_rhs;
   logic [4:0]  i_req0_tag, i_req1_tag;
   logic        o_rsp_valid, i_rsp_ready;
   logic [31:0] o_rsp_data;
   logic        o_rsp_id;
   logic [4:0]  o_rsp_tag;
   logic [15:0] o_gnt_cnt0, o_gnt_cnt1;

   logic        w2_req0_ready, w2_req1_ready, w2_rsp_valid, w2_rsp_id;
   logic [31:0] w2_rsp_data;
   logic [4:0]  w2_rsp_tag;
   logic [1:0]  w2_gnt_cnt0, w2_gnt_cnt1;

   always #5 i_clk = ~i_clk;

   bure_alu_arb #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
      .i_req0_force_add(i_req0_force_add), .i_req0_funct3(i_req0_funct3),
      .i_req0_funct7(i_req0_funct7), .i_req0_lhs(i_req0_lhs), .i_req0_rhs(i_req0_rhs),
      .i_req0_tag(i_req0_tag),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
      .i_req1_force_add(i_req1_force_add), .i_req1_funct3(i_req1_funct3),
      .i_req1_funct7(i_req1_funct7), .i_req1_lhs(i_req1_lhs), .i_req1_rhs(i_req1_rhs),
      .i_req1_tag(i_req1_tag),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
      .o_rsp_id(o_rsp_id), .o_rsp_tag(o_rsp_tag),
      .o_gnt_cnt0(o_gnt_cnt0), .o_gnt_cnt1(o_gnt_cnt1)
   );

   bure_alu_arb #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(2)) dut_w2 (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .o_req0_ready(w2_req0_ready),
      .i_req0_force_add(i_req0_force_add), .i_req0_funct3(i_req0_funct3),
      .i_req0_funct7(i_req0_funct7), .i_req0_lhs(i_req0_lhs), .i_req0_rhs(i_req0_rhs),
      .i_req0_tag(i_req0_tag),
      .i_req1_valid(i_req1_valid), .o_req1_ready(w2_req1_ready),
      .i_req1_force_add(i_req1_force_add), .i_req1_funct3(i_req1_funct3),
      .i_req1_funct7(i_req1_funct7), .i_req1_lhs(i_req1_lhs), .i_req1_rhs(i_req1_rhs),
      .i_req1_tag(i_req1_tag),
      .o_rsp_valid(w2_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(w2_rsp_data),
      .o_rsp_id(w2_rsp_id), .o_rsp_tag(w2_rsp_tag),
      .o_gnt_cnt0(w2_gnt_cnt0), .o_gnt_cnt1(w2_gnt_cnt1)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference state: contents of the response stage, arbitration history, counters
   bit          m_valid;
   logic [31:0] m_data;
   bit          m_id;
   logic [4:0]  m_tag;
   bit          m_last_was_1;
   int unsigned m_cnt0, m_cnt1;
   bit          acc0, acc1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input alu_req_t r);
      logic [4:0] sh;
      sh = r.rhs[4:0];
      if (r.force_add) return r.lhs + r.rhs;
      case (r.funct3)
         3'd0: return r.funct7[5] ? r.lhs - r.rhs : r.lhs + r.rhs;
         3'd1: return r.lhs << sh;
         3'd2: return ($signed(r.lhs) < $signed(r.rhs)) ? 32'd1 : 32'd0;
         3'd3: return (r.lhs < r.rhs) ? 32'd1 : 32'd0;
         3'd4: return r.lhs ^ r.rhs;
         3'd5: return r.funct7[5] ? 32'($signed(r.lhs) >>> sh) : r.lhs >> sh;
         3'd6: return r.lhs | r.rhs;
         default: return r.lhs & r.rhs;
      endcase
   endfunction

   function automatic alu_req_t mk(input bit fa, input int f3, input int f7,
                                   input logic [31:0] l, input logic [31:0] r, input int t);
      alu_req_t q;
      q.force_add = fa;
      q.funct3    = 3'(f3);
      q.funct7    = 7'(f7);
      q.lhs       = l;
      q.rhs       = r;
      q.tag       = 5'(t);
      return q;
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned max);
      return (v >= max) ? max : v + 1;
   endfunction

   task automatic check_outputs();
      check_eq("rsp_valid", o_rsp_valid, m_valid);
      if (m_valid) begin
         check_eq("rsp_data", o_rsp_data, m_data);
         check_eq("rsp_id", o_rsp_id, m_id);
         check_eq("rsp_tag", o_rsp_tag, m_tag);
         check_eq("w2_rsp_data", w2_rsp_data, m_data);
      end
      check_eq("w2_rsp_valid", w2_rsp_valid, m_valid);
`ifdef BURE_ALU_ARB_PERF_EN
      check_eq("gnt_cnt0", o_gnt_cnt0, (m_cnt0 > 65535) ? 65535 : m_cnt0);
      check_eq("gnt_cnt1", o_gnt_cnt1, (m_cnt1 > 65535) ? 65535 : m_cnt1);
      check_eq("w2_gnt_cnt0", w2_gnt_cnt0, (m_cnt0 > 3) ? 3 : m_cnt0);
      check_eq("w2_gnt_cnt1", w2_gnt_cnt1, (m_cnt1 > 3) ? 3 : m_cnt1);
`else
      check_eq("gnt_cnt0", o_gnt_cnt0, 0);
      check_eq("gnt_cnt1", o_gnt_cnt1, 0);
      check_eq("w2_gnt_cnt0", w2_gnt_cnt0, 0);
      check_eq("w2_gnt_cnt1", w2_gnt_cnt1, 0);
`endif
   endtask

   task automatic drive(input bit v0, input alu_req_t r0, input bit v1, input alu_req_t r1,
                        input bit rdy);
      i_req0_valid = v0;           i_req1_valid = v1;
      i_req0_force_add = r0.force_add; i_req1_force_add = r1.force_add;
      i_req0_funct3 = r0.funct3;   i_req1_funct3 = r1.funct3;
      i_req0_funct7 = r0.funct7;   i_req1_funct7 = r1.funct7;
      i_req0_lhs = r0.lhs;         i_req1_lhs = r1.lhs;
      i_req0_rhs = r0.rhs;         i_req1_rhs = r1.rhs;
      i_req0_tag = r0.tag;         i_req1_tag = r1.tag;
      i_rsp_ready = rdy;
   endtask

   // One clock: apply inputs, check readies, advance the model, check the response stage
   task automatic cycle(input bit v0, input alu_req_t r0, input bit v1, input alu_req_t r1,
                        input bit rdy);
      bit free;
      int winner;
      drive(v0, r0, v1, r1, rdy);
      #1;
      free = !m_valid || rdy;
      if (v0 && v1)  winner = m_last_was_1 ? 0 : 1;
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
      else           winner = -1;
      acc0 = free && (winner == 0);
      acc1 = free && (winner == 1);
      check_eq("req0_ready", o_req0_ready, acc0);
      check_eq("req1_ready", o_req1_ready, acc1);
      check_eq("w2_req0_ready", w2_req0_ready, acc0);
      @(posedge i_clk);
      if (acc0 || acc1) begin
         m_valid      = 1;
         m_data       = ref_alu(acc1 ? r1 : r0);
         m_id         = acc1;
         m_tag        = acc1 ? r1.tag : r0.tag;
         m_last_was_1 = acc1;
         if (acc0) m_cnt0 = sat(m_cnt0, 65535);
         if (acc1) m_cnt1 = sat(m_cnt1, 65535);
      end else if (rdy) begin
         m_valid = 0;
      end
      #1;
      check_outputs();
   endtask

   task automatic reset_dut();
      i_rst = 1'b1;
      #1;
      check_eq("rst_req0_ready", o_req0_ready, 0);
      check_eq("rst_req1_ready", o_req1_ready, 0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      m_valid = 0; m_data = '0; m_id = 0; m_tag = '0;
      m_last_was_1 = 1; m_cnt0 = 0; m_cnt1 = 0;
      check_outputs();
      check_eq("rst_data", o_rsp_data, 0);
      check_eq("rst_id", o_rsp_id, 0);
      check_eq("rst_tag", o_rsp_tag, 0);
   endtask

   alu_req_t q_idle, q_add, q_sub, q_xor, q_256, q_fa;
   alu_req_t rq0, rq1;
   bit       rv0, rv1;

   initial begin
      q_idle = mk(0, 0, 0, 32'h0, 32'h0, 0);
      q_add  = mk(0, 0, 0, 32'd5, 32'd7, 3);
      q_sub  = mk(0, 0, 7'h20, 32'd10, 32'd4, 1);
      q_xor  = mk(0, 4, 0, 32'hF0, 32'h0F, 2);
      q_256  = mk(0, 0, 0, 32'h80, 32'h80, 9);
      q_fa   = mk(1, 1, 7'h20, 32'h1000, 32'h24, 17);

      i_rst = 1'b1;
      drive(0, q_idle, 0, q_idle, 1);
      @(posedge i_clk);
      #1;
      reset_dut();

      // Single request, latency 1
      cycle(1, q_add, 0, q_idle, 1);
      check_eq("add_data", o_rsp_data, 12);
      check_eq("add_id", o_rsp_id, 0);
      check_eq("add_tag", o_rsp_tag, 3);

      // Continuous contention alternates starting with port 0
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         cycle(1, q_sub, 1, q_xor, 1);
         check_eq("alt_id", o_rsp_id, i % 2);
         check_eq("alt_data", o_rsp_data, (i % 2) ? 32'hFF : 32'd6);
      end

      // Backpressure holds the stage and blocks both ports
      cycle(1, q_256, 0, q_idle, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, q_sub, 1, q_xor, 0);
         check_eq("bp_data", o_rsp_data, 32'h100);
         check_eq("bp_valid", o_rsp_valid, 1);
      end
      cycle(1, q_sub, 1, q_xor, 1);
      check_eq("bp_refill_id", o_rsp_id, 1);
      check_eq("bp_refill_data", o_rsp_data, 32'hFF);

      // force_add overrides funct3/funct7
      cycle(0, q_idle, 1, q_fa, 1);
      check_eq("force_add_data", o_rsp_data, 32'h1024);

      // Reset while a result is held and both ports are requesting
      cycle(1, q_sub, 1, q_xor, 0);
      reset_dut();
      cycle(1, q_sub, 1, q_xor, 1);
      check_eq("post_rst_id", o_rsp_id, 0);

      // Counter run: 5 port-0 then 3 port-1 accepts
      reset_dut();
      for (int i = 0; i < 5; i++) cycle(1, q_add, 0, q_idle, 1);
      for (int i = 0; i < 3; i++) cycle(0, q_idle, 1, q_xor, 1);
`ifdef BURE_ALU_ARB_PERF_EN
      check_eq("cnt0_five", o_gnt_cnt0, 5);
      check_eq("cnt1_three", o_gnt_cnt1, 3);
      check_eq("w2_cnt0_sat", w2_gnt_cnt0, 3);
      check_eq("w2_cnt1_three", w2_gnt_cnt1, 3);
`endif

      // Random traffic; requesters hold payload until accepted
      rv0 = 0; rv1 = 0; rq0 = q_idle; rq1 = q_idle;
      for (int n = 0; n < 600; n++) begin
         if (!rv0) begin
            rv0 = ($urandom_range(0, 3) != 0);
            rq0 = mk($urandom_range(0, 5) == 0, $urandom_range(0, 7),
                     $urandom_range(0, 1) ? 7'h20 : 7'h00, $urandom, $urandom,
                     $urandom_range(0, 31));
         end
         if (!rv1) begin
            rv1 = ($urandom_range(0, 3) != 0);
            rq1 = mk($urandom_range(0, 5) == 0, $urandom_range(0, 7),
                     $urandom_range(0, 1) ? 7'h20 : 7'h00, $urandom, $urandom,
                     $urandom_range(0, 31));
         end
         if ($urandom_range(0, 149) == 0) begin
            drive(rv0, rq0, rv1, rq1, 1);
            reset_dut();
         end else begin
            cycle(rv0, rq0, rv1, rq1, $urandom_range(0, 3) != 0);
            if (acc0) rv0 = 0;
            if (acc1) rv1 = 0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
